// File: rtl/rtc_update_ctrl_if.sv
// Peripheral bus port of the RTC update controller.
// Signal suffixes are named from the controller's side: _i flows into it, _o flows out of it.
interface rtc_update_ctrl_if;
   logic        req_i;
   logic        we_i;
   logic [2:0]  addr_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface

// File: rtl/rtc_update_ctrl.sv
// RTC update controller: shadows software settings, applies them via one-cycle strobes on commit.
// Optional coherent clock/date/timer readback is enabled by defining RTC_CTRL_SNAPSHOT_EN.
module rtc_update_ctrl (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   rtc_update_ctrl_if.slave       bus,

   output logic                   clock_update_o,
   output logic                   date_update_o,
   output logic                   timer_update_o,
   output logic                   alarm_update_clock_o,
   output logic                   alarm_update_date_o,

   output logic [21:0]            clock_o,
   output logic [31:0]            date_o,
   output logic [16:0]            timer_target_o,
   output logic [21:0]            alarm_clock_o,
   output logic [31:0]            alarm_date_o,

   output logic                   timer_enable_o,
   output logic                   timer_retrig_o,
   output logic                   alarm_enable_o,
   output logic [5:0]             alarm_mask_o,

   input  logic [21:0]            clock_i,
   input  logic [31:0]            date_i,
   input  logic [16:0]            timer_value_i,
   input  logic                   event_i,
   output logic                   irq_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [4:0]  r_pending;
   logic [4:0]  w_load;
   logic [4:0]  w_strobe;
   logic [4:0]  w_pending_left;

   logic [21:0] r_clock;
   logic [31:0] r_date;
   logic [16:0] r_timer_target;
   logic        r_timer_en;
   logic        r_timer_retrig;
   logic [21:0] r_alarm_clock;
   logic [31:0] r_alarm_date;
   logic        r_alarm_en;
   logic [5:0]  r_alarm_mask;
   logic        r_irq_en;
   logic        r_event;

   logic        r_rvalid;
   logic [31:0] r_rdata;
   logic [31:0] w_rdata;
   logic [31:0] w_date_rd;
   logic [16:0] w_timer_rd;

   logic        w_busy;
   logic        w_wr;
   logic        w_rd;
   logic        w_commit;
   logic        w_w1c;

   // Reads and STATUS writes must never stall so software can poll busy and clear events.
   assign w_busy    = (r_state != ST_IDLE);
   assign bus.gnt_o = bus.req_i && !(bus.we_i && (bus.addr_i != 3'd7) && w_busy);
   assign w_wr      = bus.req_i && bus.we_i && bus.gnt_o;
   assign w_rd      = bus.req_i && !bus.we_i && bus.gnt_o;
   assign w_commit  = w_wr && (bus.addr_i == 3'd6) && bus.wdata_i[0] && (r_pending != 5'd0);
   assign w_w1c     = w_wr && (bus.addr_i == 3'd7) && bus.wdata_i[0];

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_load
         assign w_load[gi] = w_wr && (bus.addr_i == 3'(gi));
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_commit) w_state_next = ST_APPLY;
         ST_APPLY: if (w_pending_left == 5'd0) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Isolating the lowest set bit gives the fixed CLOCK..ALARM_DATE order with one strobe per cycle.
   always_comb begin
      w_strobe = 5'd0;
      if (r_state == ST_APPLY) begin
         w_strobe = r_pending & (~r_pending + 5'd1);
      end
   end

   assign w_pending_left = r_pending & ~w_strobe;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_pending <= 5'd0;
      end else if (r_state == ST_APPLY) begin
         r_pending <= w_pending_left;
      end else begin
         r_pending <= r_pending | w_load;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_clock        <= 22'd0;
         r_date         <= 32'h0000_0101;
         r_timer_target <= 17'd0;
         r_timer_en     <= 1'b0;
         r_timer_retrig <= 1'b0;
         r_alarm_clock  <= 22'd0;
         r_alarm_date   <= 32'd0;
         r_alarm_en     <= 1'b0;
         r_alarm_mask   <= 6'd0;
         r_irq_en       <= 1'b0;
      end else if (w_wr) begin
         case (bus.addr_i)
            3'd0: r_clock <= bus.wdata_i[21:0];
            3'd1: r_date  <= bus.wdata_i;
            3'd2: begin
               r_timer_target <= bus.wdata_i[16:0];
               r_timer_en     <= bus.wdata_i[17];
               r_timer_retrig <= bus.wdata_i[18];
            end
            3'd3: r_alarm_clock <= bus.wdata_i[21:0];
            3'd4: r_alarm_date  <= bus.wdata_i;
            3'd5: begin
               r_alarm_en   <= bus.wdata_i[0];
               r_alarm_mask <= bus.wdata_i[6:1];
               r_irq_en     <= bus.wdata_i[7];
            end
            default: ;
         endcase
      end
   end

   // A new event wins over a simultaneous clear so no event is ever lost.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_event <= 1'b0;
      end else begin
         r_event <= event_i | (r_event & ~w_w1c);
      end
   end

`ifdef RTC_CTRL_SNAPSHOT_EN
   logic        r_snap_valid;
   logic [31:0] r_snap_date;
   logic [16:0] r_snap_timer;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_snap_valid <= 1'b0;
         r_snap_date  <= 32'd0;
         r_snap_timer <= 17'd0;
      end else if (w_rd) begin
         if (bus.addr_i == 3'd0) begin
            r_snap_valid <= 1'b1;
            r_snap_date  <= date_i;
            r_snap_timer <= timer_value_i;
         end else if ((bus.addr_i != 3'd1) && (bus.addr_i != 3'd2)) begin
            r_snap_valid <= 1'b0;
         end
      end
   end

   assign w_date_rd  = r_snap_valid ? r_snap_date  : date_i;
   assign w_timer_rd = r_snap_valid ? r_snap_timer : timer_value_i;
`else
   assign w_date_rd  = date_i;
   assign w_timer_rd = timer_value_i;
`endif

   always_comb begin
      w_rdata = 32'd0;
      case (bus.addr_i)
         3'd0: w_rdata = {10'd0, clock_i};
         3'd1: w_rdata = w_date_rd;
         3'd2: w_rdata = {15'd0, w_timer_rd};
         3'd3: w_rdata = {10'd0, r_alarm_clock};
         3'd4: w_rdata = r_alarm_date;
         3'd5: w_rdata = {24'd0, r_irq_en, r_alarm_mask, r_alarm_en};
         3'd7: w_rdata = {25'd0, r_pending, w_busy, r_event};
         default: w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 32'd0;
      end else begin
         r_rvalid <= bus.gnt_o;
         r_rdata  <= w_rd ? w_rdata : 32'd0;
      end
   end

   assign bus.rvalid_o = r_rvalid;
   assign bus.rdata_o  = r_rdata;

   assign clock_update_o       = w_strobe[0];
   assign date_update_o        = w_strobe[1];
   assign timer_update_o       = w_strobe[2];
   assign alarm_update_clock_o = w_strobe[3];
   assign alarm_update_date_o  = w_strobe[4];

   assign clock_o        = r_clock;
   assign date_o         = r_date;
   assign timer_target_o = r_timer_target;
   assign alarm_clock_o  = r_alarm_clock;
   assign alarm_date_o   = r_alarm_date;
   assign timer_enable_o = r_timer_en;
   assign timer_retrig_o = r_timer_retrig;
   assign alarm_enable_o = r_alarm_en;
   assign alarm_mask_o   = r_alarm_mask;
   assign irq_o          = r_event & r_irq_en;

endmodule

// File: tb/tb_rtc_update_ctrl.sv
// Directed bench for rtc_update_ctrl: bus reads are scored against a queue of expected data,
// commits are checked cycle by cycle against a small register model.
module tb_rtc_update_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   always #5 clk = ~clk;

   rtc_update_ctrl_if bus_if ();

   logic        clock_update, date_update, timer_update, alarm_update_clock, alarm_update_date;
   logic [21:0] clock_o, alarm_clock_o;
   logic [31:0] date_o, alarm_date_o;
   logic [16:0] timer_target_o;
   logic        timer_enable_o, timer_retrig_o, alarm_enable_o, irq_o;
   logic [5:0]  alarm_mask_o;
   logic [21:0] clock_i = '0;
   logic [31:0] date_i = '0;
   logic [16:0] timer_value_i = '0;
   logic        event_i = 1'b0;

   wire  [4:0]  strobes = {alarm_update_date, alarm_update_clock, timer_update, date_update, clock_update};

   rtc_update_ctrl dut (
      .clk_i                (clk),
      .rstn_i               (rstn),
      .bus                  (bus_if),
      .clock_update_o       (clock_update),
      .date_update_o        (date_update),
      .timer_update_o       (timer_update),
      .alarm_update_clock_o (alarm_update_clock),
      .alarm_update_date_o  (alarm_update_date),
      .clock_o              (clock_o),
      .date_o               (date_o),
      .timer_target_o       (timer_target_o),
      .alarm_clock_o        (alarm_clock_o),
      .alarm_date_o         (alarm_date_o),
      .timer_enable_o       (timer_enable_o),
      .timer_retrig_o       (timer_retrig_o),
      .alarm_enable_o       (alarm_enable_o),
      .alarm_mask_o         (alarm_mask_o),
      .clock_i              (clock_i),
      .date_i               (date_i),
      .timer_value_i        (timer_value_i),
      .event_i              (event_i),
      .irq_o                (irq_o)
   );

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   // register model
   logic [21:0] m_clock, m_aclk;
   logic [31:0] m_date, m_adate;
   logic [16:0] m_timer;
   logic        m_ten, m_tret, m_aen, m_irqen, m_event;
   logic [5:0]  m_amask;
   logic [4:0]  m_pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_clock = '0; m_date = 32'h0000_0101; m_timer = '0; m_aclk = '0; m_adate = '0;
      m_ten = 0; m_tret = 0; m_aen = 0; m_amask = '0; m_irqen = 0; m_event = 0; m_pend = '0;
   endtask

   task automatic model_write(input logic [2:0] addr, input logic [31:0] wd);
      case (addr)
         3'd0: begin m_clock = wd[21:0]; m_pend[0] = 1'b1; end
         3'd1: begin m_date = wd; m_pend[1] = 1'b1; end
         3'd2: begin m_timer = wd[16:0]; m_ten = wd[17]; m_tret = wd[18]; m_pend[2] = 1'b1; end
         3'd3: begin m_aclk = wd[21:0]; m_pend[3] = 1'b1; end
         3'd4: begin m_adate = wd; m_pend[4] = 1'b1; end
         3'd5: begin m_aen = wd[0]; m_amask = wd[6:1]; m_irqen = wd[7]; end
         3'd7: if (wd[0]) m_event = 1'b0;
         default: ;
      endcase
   endtask

   function automatic logic [31:0] status_exp();
      return {25'd0, m_pend, 1'b0, m_event};
   endfunction

   // One bus transaction issued in a single cycle while the controller is idle.
   task automatic bus_xfer(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                           input logic [31:0] rexp);
      logic [31:0] rd_exp;
      @(posedge clk); #1;
      bus_if.req_i = 1'b1; bus_if.we_i = we; bus_if.addr_i = addr; bus_if.wdata_i = wd;
      if (!we) exp_q.push_back(rexp);
      @(negedge clk);
      chk("bus_gnt", 32'(bus_if.gnt_o), 32'd1);
      @(posedge clk); #1;
      bus_if.req_i = 1'b0; bus_if.we_i = 1'b0;
      if (we) model_write(addr, wd);
      @(negedge clk);
      chk("bus_rvalid", 32'(bus_if.rvalid_o), 32'd1);
      if (!we) begin
         rd_exp = exp_q.pop_front();
         chk($sformatf("rdata_a%0d", addr), bus_if.rdata_o, rd_exp);
         $display("txn RD addr=%0d data=0x%08h", addr, bus_if.rdata_o);
      end else begin
         $display("txn WR addr=%0d data=0x%08h", addr, wd);
      end
   endtask

   task automatic chk_shadows(input string tag);
      chk({tag, "_clock_o"},  32'(clock_o),        32'(m_clock));
      chk({tag, "_date_o"},   date_o,              m_date);
      chk({tag, "_timer_o"},  32'(timer_target_o), 32'(m_timer));
      chk({tag, "_aclock_o"}, 32'(alarm_clock_o),  32'(m_aclk));
      chk({tag, "_adate_o"},  alarm_date_o,        m_adate);
   endtask

   // Commit, then hold a write (CLOCK probe or harmless CTRL) that must stall until IDLE.
   task automatic commit_run(input logic probe_clock, input logic [31:0] probe_data);
      logic [4:0] pend;
      int         k;
      pend = m_pend;
      k    = $countones(pend);
      @(posedge clk); #1;
      bus_if.req_i = 1'b1; bus_if.we_i = 1'b1; bus_if.addr_i = 3'd6; bus_if.wdata_i = 32'd1;
      @(negedge clk);
      chk("commit_gnt", 32'(bus_if.gnt_o), 32'd1);
      @(posedge clk); #1;
      bus_if.addr_i  = probe_clock ? 3'd0 : 3'd6;
      bus_if.wdata_i = probe_clock ? probe_data : 32'd0;
      for (int b = 0; b < 5; b++) begin
         if (pend[b]) begin
            @(negedge clk);
            chk($sformatf("strobe_p%0d", b), 32'(strobes), 32'(1) << b);
            chk("apply_stall", 32'(bus_if.gnt_o), 32'd0);
            chk_shadows("apply");
            @(posedge clk); #1;
         end
      end
      if (k > 0) begin
         @(negedge clk);
         chk("done_strobe", 32'(strobes), 32'd0);
         chk("done_stall", 32'(bus_if.gnt_o), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("idle_strobe", 32'(strobes), 32'd0);
      chk("idle_gnt", 32'(bus_if.gnt_o), 32'd1);
      @(posedge clk); #1;
      bus_if.req_i = 1'b0; bus_if.we_i = 1'b0;
      m_pend = '0;
      if (probe_clock) model_write(3'd0, probe_data);
      $display("txn COMMIT pending=0x%02h strobes=%0d probe_clock=%0d", pend, k, probe_clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d_old, d_new;
      logic [16:0] t_old, t_new;
      bus_if.req_i = 1'b0; bus_if.we_i = 1'b0; bus_if.addr_i = '0; bus_if.wdata_i = '0;
      model_reset();

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_strobes", 32'(strobes), 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_rvalid", 32'(bus_if.rvalid_o), 32'd0);
      chk("rst_ten", 32'(timer_enable_o), 32'd0);
      chk("rst_mask", 32'(alarm_mask_o), 32'd0);
      chk_shadows("rst");
      rstn = 1'b1;

      bus_xfer(1'b0, 3'd7, '0, status_exp());
      bus_xfer(1'b0, 3'd5, '0, 32'd0);
      bus_xfer(1'b0, 3'd6, '0, 32'd0);
      bus_xfer(1'b0, 3'd3, '0, 32'd0);
      bus_xfer(1'b0, 3'd4, '0, 32'd0);

      // live readback
      clock_i = 22'h0ABCDE; date_i = 32'hCAFE_0001; timer_value_i = 17'h1F0F0;
      bus_xfer(1'b0, 3'd0, '0, 32'h000A_BCDE);
      bus_xfer(1'b0, 3'd1, '0, 32'hCAFE_0001);
      bus_xfer(1'b0, 3'd2, '0, 32'h0001_F0F0);

      // TIMER write: enable acts at once, target waits for commit; DATE reset shadow seen at strobe
      bus_xfer(1'b1, 3'd2, (32'd1 << 17) | 32'h1ABCD, '0);
      chk("timer_en", 32'(timer_enable_o), 32'(m_ten));
      chk("timer_retrig", 32'(timer_retrig_o), 32'(m_tret));
      bus_xfer(1'b0, 3'd7, '0, status_exp());
      commit_run(1'b0, '0);

      // three shadows, commit, CLOCK write stalled until IDLE
      bus_xfer(1'b1, 3'd0, 32'h0001_2345, '0);
      bus_xfer(1'b1, 3'd1, 32'h2024_0301, '0);
      bus_xfer(1'b1, 3'd4, 32'h0000_0005, '0);
      bus_xfer(1'b0, 3'd7, '0, status_exp());
      commit_run(1'b1, 32'h0003_AAAA);
      bus_xfer(1'b0, 3'd7, '0, status_exp());

      // two non-adjacent pending bits, then an empty commit
      bus_xfer(1'b1, 3'd3, 32'h0002_F0F0, '0);
      commit_run(1'b0, '0);
      bus_xfer(1'b0, 3'd7, '0, status_exp());
      commit_run(1'b0, '0);
      bus_xfer(1'b0, 3'd7, '0, status_exp());

      // alarm configuration and interrupt
      bus_xfer(1'b1, 3'd5, 32'h0000_00D5, '0);
      chk("alarm_en", 32'(alarm_enable_o), 32'(m_aen));
      chk("alarm_mask", 32'(alarm_mask_o), 32'(m_amask));
      bus_xfer(1'b0, 3'd5, '0, {24'd0, m_irqen, m_amask, m_aen});
      chk("irq_idle", 32'(irq_o), 32'd0);

      @(posedge clk); #1; event_i = 1'b1;
      @(negedge clk); chk("irq_same_cycle", 32'(irq_o), 32'd0);
      @(posedge clk); #1; event_i = 1'b0; m_event = 1'b1;
      @(negedge clk); chk("irq_next_cycle", 32'(irq_o), 32'd1);
      $display("txn EVENT pulse");

      @(posedge clk); #1;
      event_i = 1'b1;
      bus_if.req_i = 1'b1; bus_if.we_i = 1'b1; bus_if.addr_i = 3'd7; bus_if.wdata_i = 32'd1;
      @(negedge clk); chk("w1c_gnt", 32'(bus_if.gnt_o), 32'd1);
      @(posedge clk); #1;
      event_i = 1'b0; bus_if.req_i = 1'b0; bus_if.we_i = 1'b0;
      @(negedge clk); chk("irq_set_wins", 32'(irq_o), 32'd1);
      $display("txn W1C with coincident event");
      bus_xfer(1'b0, 3'd7, '0, status_exp());
      bus_xfer(1'b1, 3'd7, 32'd1, '0);
      chk("irq_cleared", 32'(irq_o), 32'd0);
      bus_xfer(1'b0, 3'd7, '0, status_exp());

      // coherent readback at 23:59:59
      d_old = 32'h2024_1231; d_new = 32'h2025_0101;
      t_old = 17'h00FF0;     t_new = 17'h00FF1;
      clock_i = 22'({5'd23, 6'd59, 6'd59}); date_i = d_old; timer_value_i = t_old;
      bus_xfer(1'b0, 3'd0, '0, 32'(clock_i));
      date_i = d_new; timer_value_i = t_new;
`ifdef RTC_CTRL_SNAPSHOT_EN
      bus_xfer(1'b0, 3'd1, '0, d_old);
      bus_xfer(1'b0, 3'd2, '0, 32'(t_old));
`else
      bus_xfer(1'b0, 3'd1, '0, d_new);
      bus_xfer(1'b0, 3'd2, '0, 32'(t_new));
`endif
      bus_xfer(1'b0, 3'd7, '0, status_exp());
      bus_xfer(1'b0, 3'd1, '0, d_new);

      // reset in the middle of APPLY
      bus_xfer(1'b1, 3'd0, 32'h0001_1111, '0);
      bus_xfer(1'b1, 3'd1, 32'h2222_2222, '0);
      @(posedge clk); #1;
      bus_if.req_i = 1'b1; bus_if.we_i = 1'b1; bus_if.addr_i = 3'd6; bus_if.wdata_i = 32'd1;
      @(posedge clk); #1;
      bus_if.req_i = 1'b0; bus_if.we_i = 1'b0;
      @(negedge clk); chk("pre_reset_strobe", 32'(strobes), 32'd1);
      #1 rstn = 1'b0;
      #1 chk("reset_kills_strobe", 32'(strobes), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("reset_held_strobe", 32'(strobes), 32'd0);
      rstn = 1'b1;
      model_reset();
      $display("txn RESET during APPLY");
      chk_shadows("post_reset");
      repeat (3) begin
         @(negedge clk);
         chk("post_reset_strobe", 32'(strobes), 32'd0);
      end
      bus_xfer(1'b0, 3'd7, '0, status_exp());

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rtc_update_ctrl.md
# rtc_update_ctrl

Register-side controller for the real-time-clock datapath. It shadows software writes to clock, date, timer and alarm settings and applies them through the RTC's single-cycle update strobes in a fixed, glitch-free sequence on an explicit commit. It also provides coherent clock/date readback and a sticky, maskable event interrupt. It sits between the peripheral bus slave and the RTC core.

## Interface
- Parameters: none. Address and data widths are fixed.
- clk_i  in  1  clock
- rstn_i  in  1  reset; asynchronous assert, active-low
- req_i / we_i  in  1 / 1  bus request / write enable
- addr_i  in  3  word register index
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  read or write response valid, one cycle after gnt_o
- rdata_o  out  32  read data, qualified by rvalid_o
- clock_update_o, date_update_o, timer_update_o, alarm_update_clock_o, alarm_update_date_o  out  1 each  one-cycle apply strobes to the RTC
- clock_o 22, date_o 32, timer_target_o 17, alarm_clock_o 22, alarm_date_o 32  out  shadow values driven to the RTC
- timer_enable_o, timer_retrig_o, alarm_enable_o  out  1 each; alarm_mask_o  out  6
- clock_i 22, date_i 32, timer_value_i 17  in  live RTC values
- event_i  in  1  RTC event pulse
- irq_o  out  1  level interrupt

## Operation
- Register map:
  - 0 CLOCK[21:0]
  - 1 DATE[31:0]
  - 2 TIMER: target[16:0], enable[17], retrig[18]
  - 3 ALARM_CLOCK[21:0]
  - 4 ALARM_DATE[31:0]
  - 5 ALARM_CFG: enable[0], mask[6:1], irq_en[7]
  - 6 CTRL: commit[0], write-only
  - 7 STATUS: event[0] (W1C), busy[1], pending[6:2] (RO)
- Write to index 0–4: loads the shadow register and sets pending bit p0..p4. The RTC is not touched until commit.
- TIMER enable/retrig and ALARM_CFG drive the RTC outputs directly after the write; they need no commit.
- Reads:
  - 0/1/2 return the live clock_i / date_i / timer_value_i.
  - 3/4/5 return the shadow values.
  - Reads of 6 return 0.
- FSM states: IDLE, APPLY, DONE.
  - IDLE → APPLY: a CTRL write with commit=1 while any pending bit is set. Commit with no pending bits is ignored.
  - APPLY: each cycle, pulse the strobe of the lowest-numbered set pending bit and clear that bit. Order is CLOCK, DATE, TIMER, ALARM_CLOCK, ALARM_DATE. Exactly one strobe is high per cycle.
  - APPLY → DONE: after the last pending bit clears. DONE → IDLE after one cycle.
  - busy = state ≠ IDLE.
- Bus stall: while busy, gnt_o=0 for writes to index 0–6. Reads and STATUS writes are always granted.
- Event handling:
  - event_i sets STATUS.event.
  - irq_o = event & irq_en.
  - A W1C in the same cycle as event_i leaves the bit set (set wins).
- Reset values:
  - All outputs 0, state IDLE, pending 0.
  - Shadows: CLOCK 0, DATE 0x0000_0101, others 0.

## Timing
- gnt_o is combinational from req_i/we_i/addr_i/state.
- rvalid_o and rdata_o are registered and valid exactly one cycle after gnt_o.
- For a commit granted in cycle N, the first strobe is in N+1. With k pending bits, strobes occupy N+1..N+k, DONE is N+k+1, and IDLE (busy=0) is N+k+2.
- Shadow data outputs are stable during and after their strobe cycle.
- irq_o follows STATUS.event with one cycle of latency from event_i.
- Reset asserted mid-APPLY returns immediately to IDLE. No further strobes are issued and pending bits clear.

## Configuration
- RTC_CTRL_SNAPSHOT_EN defined:
  - A read of CLOCK latches date_i and timer_value_i into snapshot registers in the same cycle.
  - A following read of DATE or TIMER returns the snapshot if no other register read intervenes; otherwise it returns the live value.
  - Any read other than DATE/TIMER invalidates the snapshot.
- Undefined: DATE and TIMER reads always return live values, and no snapshot registers exist.

## Test plan
- Reset → all strobes 0, irq_o 0, STATUS reads 0, DATE shadow reads 0x0000_0101 via commit.
- Write CLOCK=0x12345, DATE=0x20240301, ALARM_DATE=0x5, then commit:
  - clock_update_o, date_update_o and alarm_update_date_o each pulse in consecutive cycles N+1..N+3 with the matching data.
  - busy clears at N+5.
- Write CLOCK during APPLY → gnt_o=0 until IDLE, then the write is accepted and p0 is set.
- Commit with pending=0 → no strobe, busy stays 0.
- irq_en=1 and event_i pulse → irq_o=1 next cycle. W1C STATUS coincident with a second event_i leaves irq_o at 1. A later W1C alone clears it.
- With RTC_CTRL_SNAPSHOT_EN: read CLOCK at 23:59:59, date_i changes, then read DATE → the old date is returned. Without the macro → the new date is returned.
